// File: rtl/blit_coord_gen_if.sv
// Command/pixel bundle for blit_coord_gen.
// The cmd_reverse signal exists only when BLIT_COORD_REVERSE_EN is defined.
interface blit_coord_gen_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_width;
  logic [15:0] cmd_height;
  logic [15:0] cmd_dest_x;
  logic [15:0] cmd_dest_y;
  logic [15:0] cmd_src_x;
  logic [15:0] cmd_src_y;
  logic [15:0] cmd_color;
`ifdef BLIT_COORD_REVERSE_EN
  logic        cmd_reverse;
`endif
  logic [15:0] p2_dest_x;
  logic [15:0] p2_dest_y;
  logic [15:0] p2_src_x;
  logic [15:0] p2_src_y;
  logic [15:0] p2_color;
  logic        p2_write;
  logic        busy;
  logic        done;

  // Command processor side
  modport master (
    output cmd_valid, cmd_width, cmd_height, cmd_dest_x, cmd_dest_y,
           cmd_src_x, cmd_src_y, cmd_color,
`ifdef BLIT_COORD_REVERSE_EN
    output cmd_reverse,
`endif
    input  cmd_ready, p2_dest_x, p2_dest_y, p2_src_x, p2_src_y, p2_color,
           p2_write, busy, done
  );

  // Rectangle walker side
  modport slave (
    input  cmd_valid, cmd_width, cmd_height, cmd_dest_x, cmd_dest_y,
           cmd_src_x, cmd_src_y, cmd_color,
`ifdef BLIT_COORD_REVERSE_EN
    input  cmd_reverse,
`endif
    output cmd_ready, p2_dest_x, p2_dest_y, p2_src_x, p2_src_y, p2_color,
           p2_write, busy, done
  );
endinterface

// File: rtl/blit_coord_gen.sv
// Blitter rectangle walker: accepts one rectangle command and emits one pixel
// coordinate set per unstalled cycle in raster order.
// Optional feature: define BLIT_COORD_REVERSE_EN to enable the reverse
// (bottom-right to top-left) walk selected per command by cmd_reverse.
module blit_coord_gen (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  blit_coord_gen_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [15:0] w_q, w_d, h_q, h_d;
  logic [15:0] col_q, col_d, row_q, row_d;
  logic [15:0] dx_org_q, dx_org_d, dy_org_q, dy_org_d;
  logic [15:0] sx_org_q, sx_org_d, sy_org_q, sy_org_d;
  logic [15:0] color_q, color_d;
  logic [15:0] dst_x_q, dst_x_d, dst_y_q, dst_y_d;
  logic [15:0] src_x_q, src_x_d, src_y_q, src_y_d;
  logic        write_q, write_d;
  logic        done_q, done_d;
  logic        rev_eff;
  logic        accept;
  logic        last_pix;

`ifdef BLIT_COORD_REVERSE_EN
  logic rev_q, rev_d;
  assign rev_eff = rev_d;
`else
  assign rev_eff = 1'b0;
`endif

  // Coordinate of pixel idx along one axis; wraps modulo 2^16.
  function automatic logic [15:0] walk(input logic [15:0] org, input logic [15:0] size,
                                       input logic [15:0] idx, input logic rev);
    return rev ? (org + size - 16'd1 - idx) : (org + idx);
  endfunction

  assign bus.cmd_ready = (state_q == StIdle) && !stall;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign last_pix      = (col_q == w_q - 16'd1) && (row_q == h_q - 16'd1);

  // Next-state: command latch, raster counters and registered pixel outputs.
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    h_d      = h_q;
    col_d    = col_q;
    row_d    = row_q;
    dx_org_d = dx_org_q;
    dy_org_d = dy_org_q;
    sx_org_d = sx_org_q;
    sy_org_d = sy_org_q;
    color_d  = color_q;
    dst_x_d  = dst_x_q;
    dst_y_d  = dst_y_q;
    src_x_d  = src_x_q;
    src_y_d  = src_y_q;
    write_d  = write_q;
    done_d   = done_q;
`ifdef BLIT_COORD_REVERSE_EN
    rev_d    = rev_q;
`endif
    // A stalled cycle keeps every default, so outputs stay frozen.
    if (!stall) begin
      write_d = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            w_d      = bus.cmd_width;
            h_d      = bus.cmd_height;
            dx_org_d = bus.cmd_dest_x;
            dy_org_d = bus.cmd_dest_y;
            sx_org_d = bus.cmd_src_x;
            sy_org_d = bus.cmd_src_y;
            color_d  = bus.cmd_color;
            col_d    = 16'd0;
            row_d    = 16'd0;
`ifdef BLIT_COORD_REVERSE_EN
            rev_d    = bus.cmd_reverse;
`endif
            if (bus.cmd_width == 16'd0 || bus.cmd_height == 16'd0) begin
              done_d = 1'b1;
            end else begin
              state_d = StRun;
              write_d = 1'b1;
            end
          end
        end
        StRun: begin
          if (last_pix) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            write_d = 1'b1;
            if (col_q == w_q - 16'd1) begin
              col_d = 16'd0;
              row_d = row_q + 16'd1;
            end else begin
              col_d = col_q + 16'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
      // Coordinates are derived from the counters the new pixel will carry.
      if (write_d) begin
        dst_x_d = walk(dx_org_d, w_d, col_d, rev_eff);
        dst_y_d = walk(dy_org_d, h_d, row_d, rev_eff);
        src_x_d = walk(sx_org_d, w_d, col_d, rev_eff);
        src_y_d = walk(sy_org_d, h_d, row_d, rev_eff);
      end
    end
  end

  // State register; synchronous reset abandons any command in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      w_q      <= 16'd0;
      h_q      <= 16'd0;
      col_q    <= 16'd0;
      row_q    <= 16'd0;
      dx_org_q <= 16'd0;
      dy_org_q <= 16'd0;
      sx_org_q <= 16'd0;
      sy_org_q <= 16'd0;
      color_q  <= 16'd0;
      dst_x_q  <= 16'd0;
      dst_y_q  <= 16'd0;
      src_x_q  <= 16'd0;
      src_y_q  <= 16'd0;
      write_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef BLIT_COORD_REVERSE_EN
      rev_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
      row_q    <= row_d;
      dx_org_q <= dx_org_d;
      dy_org_q <= dy_org_d;
      sx_org_q <= sx_org_d;
      sy_org_q <= sy_org_d;
      color_q  <= color_d;
      dst_x_q  <= dst_x_d;
      dst_y_q  <= dst_y_d;
      src_x_q  <= src_x_d;
      src_y_q  <= src_y_d;
      write_q  <= write_d;
      done_q   <= done_d;
`ifdef BLIT_COORD_REVERSE_EN
      rev_q    <= rev_d;
`endif
    end
  end

  assign bus.p2_dest_x = dst_x_q;
  assign bus.p2_dest_y = dst_y_q;
  assign bus.p2_src_x  = src_x_q;
  assign bus.p2_src_y  = src_y_q;
  assign bus.p2_color  = color_q;
  assign bus.p2_write  = write_q;
  assign bus.busy      = (state_q == StRun);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_blit_coord_gen.sv
// Self-checking bench for blit_coord_gen; the reverse-walk test is included
// when BLIT_COORD_REVERSE_EN is defined.
module tb_blit_coord_gen;

  logic clock = 1'b0;
  logic reset;
  logic stall;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  blit_coord_gen_if bus ();

  blit_coord_gen dut (
    .clock (clock),
    .reset (reset),
    .stall (stall),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic junk_cmd();
    bus.cmd_width  = 16'($urandom);
    bus.cmd_height = 16'($urandom);
    bus.cmd_dest_x = 16'($urandom);
    bus.cmd_dest_y = 16'($urandom);
    bus.cmd_src_x  = 16'($urandom);
    bus.cmd_src_y  = 16'($urandom);
    bus.cmd_color  = 16'($urandom);
`ifdef BLIT_COORD_REVERSE_EN
    bus.cmd_reverse = 1'($urandom);
`endif
  endtask

  // Issue one command and check every output cycle against the raster model.
  // Ends in the done cycle (state idle), so a following call chains directly.
  task automatic do_cmd(input logic [15:0] w, input logic [15:0] h,
                        input logic [15:0] dx, input logic [15:0] dy,
                        input logic [15:0] sx, input logic [15:0] sy,
                        input logic [15:0] color, input logic rev,
                        input int stall_at, input int stall_len, input bit rnd);
    int n;
    int r;
    int c;
    int s;
    logic [15:0] ex, ey, esx, esy;
    chk("ready_before_accept", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_width  = w;
    bus.cmd_height = h;
    bus.cmd_dest_x = dx;
    bus.cmd_dest_y = dy;
    bus.cmd_src_x  = sx;
    bus.cmd_src_y  = sy;
    bus.cmd_color  = color;
`ifdef BLIT_COORD_REVERSE_EN
    bus.cmd_reverse = rev;
`endif
    bus.cmd_valid  = 1'b1;
    tick();
    bus.cmd_valid  = 1'b0;
    junk_cmd();
    n = int'(w) * int'(h);
    for (int k = 0; k < n; k++) begin
      r   = k / int'(w);
      c   = k % int'(w);
      ex  = 16'(rev ? int'(dx) + int'(w) - 1 - c : int'(dx) + c);
      ey  = 16'(rev ? int'(dy) + int'(h) - 1 - r : int'(dy) + r);
      esx = 16'(rev ? int'(sx) + int'(w) - 1 - c : int'(sx) + c);
      esy = 16'(rev ? int'(sy) + int'(h) - 1 - r : int'(sy) + r);
      chk("pix_dest", {bus.p2_dest_x, bus.p2_dest_y}, {ex, ey});
      chk("pix_src", {bus.p2_src_x, bus.p2_src_y}, {esx, esy});
      chk("pix_color", 32'(bus.p2_color), 32'(color));
      chk("pix_write", 32'(bus.p2_write), 32'd1);
      chk("pix_busy", 32'(bus.busy), 32'd1);
      chk("pix_done", 32'(bus.done), 32'd0);
      s = (k == stall_at) ? stall_len : ((rnd && $urandom_range(0, 3) == 0) ? 1 : 0);
      for (int j = 0; j < s; j++) begin
        stall = 1'b1;
        tick();
        chk("stall_dest", {bus.p2_dest_x, bus.p2_dest_y}, {ex, ey});
        chk("stall_write", 32'(bus.p2_write), 32'd1);
        chk("stall_ready", 32'(bus.cmd_ready), 32'd0);
      end
      stall = 1'b0;
      tick();
    end
    chk("done_write", 32'(bus.p2_write), 32'd0);
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_ready", 32'(bus.cmd_ready), 32'd1);
    chk("done_color", 32'(bus.p2_color), 32'(color));
  endtask

  initial begin
    logic [15:0] rw, rh;
    logic        rrev;
    reset         = 1'b1;
    stall         = 1'b0;
    bus.cmd_valid = 1'b0;
    junk_cmd();
`ifdef BLIT_COORD_REVERSE_EN
    bus.cmd_reverse = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_write", 32'(bus.p2_write), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_dest", {bus.p2_dest_x, bus.p2_dest_y}, 32'd0);
    chk("rst_src", {bus.p2_src_x, bus.p2_src_y}, 32'd0);
    chk("rst_color", 32'(bus.p2_color), 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
    stall = 1'b1;
    #1;
    chk("stall_blocks_ready", 32'(bus.cmd_ready), 32'd0);
    stall = 1'b0;
    #1;

    // Basic 3x2
    do_cmd(16'd3, 16'd2, 16'd10, 16'd20, 16'd100, 16'd200, 16'h1234, 1'b0, -1, 0, 1'b0);
    tick();
    chk("done_one_cycle", 32'(bus.done), 32'd0);

    // Zero width
    do_cmd(16'd0, 16'd5, 16'd1, 16'd2, 16'd3, 16'd4, 16'hABCD, 1'b0, -1, 0, 1'b0);
    tick();
    chk("zero_no_write", 32'(bus.p2_write), 32'd0);

    // Stall held 3 cycles after the 2nd pixel
    do_cmd(16'd4, 16'd1, 16'd7, 16'd8, 16'd9, 16'd10, 16'h5555, 1'b0, 1, 3, 1'b0);
    tick();

    // Reset mid-run of an 8x8 command, after pixel 5
    bus.cmd_width  = 16'd8;
    bus.cmd_height = 16'd8;
    bus.cmd_dest_x = 16'd10;
    bus.cmd_dest_y = 16'd10;
    bus.cmd_src_x  = 16'd0;
    bus.cmd_src_y  = 16'd0;
    bus.cmd_color  = 16'h00FF;
`ifdef BLIT_COORD_REVERSE_EN
    bus.cmd_reverse = 1'b0;
`endif
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (4) tick();
    chk("rstmid_pix5", 32'(bus.p2_dest_x), 32'd14);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_write", 32'(bus.p2_write), 32'd0);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_done", 32'(bus.done), 32'd0);
    tick();
    chk("rstmid_no_done", 32'(bus.done), 32'd0);
    do_cmd(16'd1, 16'd1, 16'd33, 16'd44, 16'd55, 16'd66, 16'h0F0F, 1'b0, -1, 0, 1'b0);
    tick();

    // Back-to-back with x wrap; second command accepted in the done cycle
    do_cmd(16'd2, 16'd1, 16'hFFFF, 16'd0, 16'hFFFF, 16'd1, 16'h2222, 1'b0, -1, 0, 1'b0);
    do_cmd(16'd1, 16'd1, 16'd5, 16'd5, 16'd6, 16'd6, 16'h3333, 1'b0, -1, 0, 1'b0);
    tick();

`ifdef BLIT_COORD_REVERSE_EN
    do_cmd(16'd2, 16'd2, 16'd10, 16'd20, 16'd30, 16'd40, 16'h4444, 1'b1, -1, 0, 1'b0);
    tick();
`endif

    // Randomized commands with random stalls and idle gaps
    for (int t = 0; t < 16; t++) begin
      rw   = 16'($urandom_range(0, 4));
      rh   = 16'($urandom_range(0, 4));
      rrev = 1'b0;
`ifdef BLIT_COORD_REVERSE_EN
      rrev = 1'($urandom);
`endif
      do_cmd(rw, rh, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), rrev, -1, 0, 1'b1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick();
        chk("gap_write", 32'(bus.p2_write), 32'd0);
        chk("gap_done", 32'(bus.done), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
